l2_host_rsp_ctrl: RTL and testbench

Responder-side companion of the L2 stream controller's host request/response interface. Accepts per-stream cache-line requests (stream id + EA), forwards them to the host memory read port with a tag, and allocates the destination L2 slot from a per-stream write pointer. Writes each returned line into the L2 URAM, then returns a per-line completion (stream id) to the stream controller. Sits between the L2 control top and the host memory read interface.

---
 rtl/l2_host_rsp_ctrl.sv | 131 +++++++++++++
 tb/tb_l2_host_rsp_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_host_rsp_ctrl.sv
// Host read responder for the L2 stream controller: tags cache-line reads,
// allocates per-stream L2 slots, writes returned lines to URAM and reports completions.
module l2_host_rsp_ctrl #(
  parameter int addr_width   = 64,
  parameter int cache_line   = 128,
  parameter int nstrms       = 64,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int l2_ncl       = 256,
  parameter int l2_ncl_width = $clog2(l2_ncl),
  parameter int ntags        = 32,
  parameter int tag_width    = $clog2(ntags)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [nstrms-1:0]         i_clr_v,
  input  logic                      i_req_v,
  output logic                      i_req_r,
  input  logic [nstrms_width-1:0]   i_req_sid,
  input  logic [addr_width-1:0]     i_req_ea,
  output logic                      m_req_v,
  input  logic                      m_req_r,
  output logic [tag_width-1:0]      m_req_tag,
  output logic [addr_width-1:0]     m_req_ea,
  input  logic                      m_rsp_v,
  output logic                      m_rsp_r,
  input  logic [tag_width-1:0]      m_rsp_tag,
  input  logic [cache_line*8-1:0]   m_rsp_data,
  output logic                      o_wr_v,
  input  logic                      o_wr_r,
  output logic [nstrms_width-1:0]   o_wr_sid,
  output logic [l2_ncl_width-1:0]   o_wr_ptr,
  output logic [cache_line*8-1:0]   o_wr_data,
  output logic                      o_rsp_v,
  input  logic                      o_rsp_r,
  output logic [nstrms_width-1:0]   o_rsp_sid
);

  logic [l2_ncl_width-1:0] wptr    [nstrms];
  logic [nstrms_width-1:0] ent_sid [ntags];
  logic [l2_ncl_width-1:0] ent_ptr [ntags];

  logic [tag_width-1:0]    wi, ri;
  logic [tag_width:0]      cnt;
  logic                    w_full, r_full;
  logic [nstrms_width-1:0] w_sid, r_sid;
  logic [l2_ncl_width-1:0] w_ptr;
  logic [cache_line*8-1:0] w_data;

  logic                    not_full, req_fire, rsp_fire, w_fire, r_fire;
  logic [l2_ncl_width-1:0] req_ptr;

  assign not_full  = (cnt != (tag_width+1)'(ntags));
  assign m_req_v   = i_req_v & not_full;
  assign i_req_r   = m_req_r & not_full;
  assign m_req_tag = wi;
  assign m_req_ea  = i_req_ea;
  assign req_fire  = i_req_v & i_req_r;

  assign w_fire    = o_wr_v & o_wr_r;
  assign m_rsp_r   = ~w_full | w_fire;
  assign rsp_fire  = m_rsp_v & m_rsp_r;

  assign o_wr_v    = w_full & (~r_full | o_rsp_r);
  assign o_wr_sid  = w_sid;
  assign o_wr_ptr  = w_ptr;
  assign o_wr_data = w_data;

  assign o_rsp_v   = r_full;
  assign o_rsp_sid = r_sid;
  assign r_fire    = r_full & o_rsp_r;

  // A clear in the same cycle as a request to that stream allocates slot 0.
  assign req_ptr = i_clr_v[i_req_sid] ? '0 : wptr[i_req_sid];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < nstrms; s++) wptr[s] <= '0;
      wi     <= '0;
      ri     <= '0;
      cnt    <= '0;
      w_full <= 1'b0;
      r_full <= 1'b0;
      w_sid  <= '0;
      w_ptr  <= '0;
      r_sid  <= '0;
    end else begin
      for (int unsigned s = 0; s < nstrms; s++) begin
        if (i_clr_v[s]) wptr[s] <= '0;
      end
      if (req_fire) begin
        wptr[i_req_sid] <= req_ptr + 1'b1;
        wi              <= wi + 1'b1;
      end

      if (rsp_fire) begin
        w_full <= 1'b1;
        w_sid  <= ent_sid[ri];
        w_ptr  <= ent_ptr[ri];
        ri     <= ri + 1'b1;
      end else if (w_fire) begin
        w_full <= 1'b0;
      end

      if (w_fire) begin
        r_full <= 1'b1;
        r_sid  <= w_sid;
      end else if (r_fire) begin
        r_full <= 1'b0;
      end

      // The tag stays reserved until its URAM write completes.
      case ({req_fire, w_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      ent_sid[wi] <= i_req_sid;
      ent_ptr[wi] <= req_ptr;
    end
    if (rsp_fire) w_data <= m_rsp_data;
  end

  tag_order_chk : assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> (m_rsp_tag == ri));

endmodule

// File: tb/tb_l2_host_rsp_ctrl.sv
// Directed bench for l2_host_rsp_ctrl: single line, pointer wrap, tag-full
// backpressure, write/completion stalls, clear collision and async reset.
module tb_l2_host_rsp_ctrl;

  logic           clk = 1'b0;
  logic           reset;
  logic [63:0]    i_clr_v;
  logic           i_req_v, i_req_r;
  logic [5:0]     i_req_sid;
  logic [63:0]    i_req_ea;
  logic           m_req_v, m_req_r;
  logic [4:0]     m_req_tag;
  logic [63:0]    m_req_ea;
  logic           m_rsp_v, m_rsp_r;
  logic [4:0]     m_rsp_tag;
  logic [1023:0]  m_rsp_data;
  logic           o_wr_v, o_wr_r;
  logic [5:0]     o_wr_sid;
  logic [7:0]     o_wr_ptr;
  logic [1023:0]  o_wr_data;
  logic           o_rsp_v, o_rsp_r;
  logic [5:0]     o_rsp_sid;

  int checks = 0;
  int errors = 0;
  logic [4:0] wi_m = '0;
  logic [4:0] ri_m = '0;

  always #5 clk = ~clk;

  l2_host_rsp_ctrl #(
    .addr_width(64), .cache_line(128), .nstrms(64), .l2_ncl(256), .ntags(32)
  ) dut (
    .clk(clk), .reset(reset), .i_clr_v(i_clr_v),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid), .i_req_ea(i_req_ea),
    .m_req_v(m_req_v), .m_req_r(m_req_r), .m_req_tag(m_req_tag), .m_req_ea(m_req_ea),
    .m_rsp_v(m_rsp_v), .m_rsp_r(m_rsp_r), .m_rsp_tag(m_rsp_tag), .m_rsp_data(m_rsp_data),
    .o_wr_v(o_wr_v), .o_wr_r(o_wr_r), .o_wr_sid(o_wr_sid), .o_wr_ptr(o_wr_ptr),
    .o_wr_data(o_wr_data), .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_sid(o_rsp_sid)
  );

  // One request followed by its response; returns the issued tag and written slot.
  task automatic line(input logic [5:0] sid, input logic [63:0] clr, input logic [31:0] seed,
                      output logic [4:0] tag, output logic [7:0] ptr, output logic ok);
    logic [1023:0] d;
    d = {32{seed}};
    @(negedge clk);
    i_req_v = 1'b1; i_req_sid = sid; i_req_ea = 64'(seed) << 7; i_clr_v = clr;
    #1 tag = m_req_tag;
    ok = i_req_r && m_req_v && (m_req_ea == i_req_ea);
    @(posedge clk); wi_m++;
    @(negedge clk);
    i_req_v = 1'b0; i_clr_v = '0;
    m_rsp_v = 1'b1; m_rsp_tag = ri_m; m_rsp_data = d;
    #1 ok = ok && m_rsp_r;
    @(posedge clk); ri_m++;
    @(negedge clk);
    m_rsp_v = 1'b0;
    #1 ok = ok && o_wr_v && (o_wr_sid == sid) && (o_wr_data == d);
    ptr = o_wr_ptr;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_clr_v = '0; i_req_v = 1'b0; i_req_sid = '0; i_req_ea = '0;
    m_req_r = 1'b0; m_rsp_v = 1'b0; m_rsp_tag = '0; m_rsp_data = '0;
    o_wr_r = 1'b1; o_rsp_r = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (i_req_r !== 1'b0) begin errors++; $display("FAIL reset_i_req_r: got %b want 0", i_req_r); end
    m_req_r = 1'b1; #1;
    checks++; if (i_req_r !== 1'b1) begin errors++; $display("FAIL reset_i_req_r_ready: got %b want 1", i_req_r); end
    checks++; if (m_req_v !== 1'b0) begin errors++; $display("FAIL reset_m_req_v: got %b want 0", m_req_v); end
    checks++; if (m_rsp_r !== 1'b1) begin errors++; $display("FAIL reset_m_rsp_r: got %b want 1", m_rsp_r); end
    checks++; if (o_wr_v !== 1'b0) begin errors++; $display("FAIL reset_o_wr_v: got %b want 0", o_wr_v); end
    checks++; if (o_rsp_v !== 1'b0) begin errors++; $display("FAIL reset_o_rsp_v: got %b want 0", o_rsp_v); end
    wi_m = '0; ri_m = '0;
  endtask

  task automatic test_single();
    logic [1023:0] d;
    d = {32{32'hA5C3_0F01}};
    @(negedge clk);
    i_req_v = 1'b1; i_req_sid = 6'd5; i_req_ea = 64'h1000;
    #1;
    checks++; if ({m_req_v, i_req_r} !== 2'b11) begin errors++; $display("FAIL single_req_valid: got v=%b r=%b want 1 1", m_req_v, i_req_r); end
    checks++; if (m_req_tag !== 5'd0) begin errors++; $display("FAIL single_tag: got %0d want 0", m_req_tag); end
    checks++; if (m_req_ea !== 64'h1000) begin errors++; $display("FAIL single_ea: got %h want 1000", m_req_ea); end
    @(posedge clk); wi_m++;
    @(negedge clk);
    i_req_v = 1'b0; m_rsp_v = 1'b1; m_rsp_tag = 5'd0; m_rsp_data = d;
    #1;
    checks++; if (m_rsp_r !== 1'b1) begin errors++; $display("FAIL single_rsp_r: got %b want 1", m_rsp_r); end
    @(posedge clk); ri_m++;
    @(negedge clk);
    m_rsp_v = 1'b0;
    #1;
    checks++; if ({o_wr_v, o_wr_sid, o_wr_ptr} !== {1'b1, 6'd5, 8'd0}) begin errors++;
      $display("FAIL single_wr: got v=%b sid=%0d ptr=%0d want 1 5 0", o_wr_v, o_wr_sid, o_wr_ptr); end
    checks++; if (o_wr_data !== d) begin errors++; $display("FAIL single_wr_data: got %h want %h", o_wr_data[31:0], d[31:0]); end
    checks++; if (o_rsp_v !== 1'b0) begin errors++; $display("FAIL single_rsp_early: got %b want 0", o_rsp_v); end
    @(negedge clk); #1;
    checks++; if ({o_rsp_v, o_rsp_sid, o_wr_v} !== {1'b1, 6'd5, 1'b0}) begin errors++;
      $display("FAIL single_rsp: got v=%b sid=%0d wr_v=%b want 1 5 0", o_rsp_v, o_rsp_sid, o_wr_v); end
    @(negedge clk); #1;
    checks++; if (o_rsp_v !== 1'b0) begin errors++; $display("FAIL single_rsp_clear: got %b want 0", o_rsp_v); end
  endtask

  task automatic test_ptr_wrap();
    logic [4:0] tag, etag;
    logic [7:0] ptr;
    logic ok;
    for (int i = 0; i < 258; i++) begin
      etag = wi_m;
      line(6'd3, '0, 32'(i), tag, ptr, ok);
      checks++;
      if ({ok, tag, ptr} !== {1'b1, etag, 8'(i % 256)}) begin errors++;
        $display("FAIL wrap[%0d]: got ok=%b tag=%0d ptr=%0d want 1 %0d %0d", i, ok, tag, ptr, etag, i % 256); end
    end
  endtask

  task automatic test_full();
    logic [4:0] t0;
    int pend, got, stalls;
    logic fire;
    t0 = wi_m;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      i_req_v = 1'b1; i_req_sid = 6'd2; i_req_ea = 64'(i) << 7;
      #1;
      checks++;
      if ({i_req_r, m_req_v, m_req_tag} !== {2'b11, t0 + 5'(i)}) begin errors++;
        $display("FAIL full_fill[%0d]: got r=%b v=%b tag=%0d want 1 1 %0d", i, i_req_r, m_req_v, m_req_tag, t0 + 5'(i)); end
      @(posedge clk); wi_m++;
    end
    @(negedge clk); #1;
    checks++; if ({i_req_r, m_req_v} !== 2'b00) begin errors++; $display("FAIL full_block: got r=%b v=%b want 0 0", i_req_r, m_req_v); end
    m_rsp_v = 1'b1; m_rsp_tag = ri_m; m_rsp_data = {32{32'h0000_F00D}};
    @(posedge clk); ri_m++;
    @(negedge clk);
    m_rsp_v = 1'b0;
    #1;
    checks++; if ({o_wr_v, i_req_r} !== 2'b10) begin errors++; $display("FAIL full_no_bypass: got wr_v=%b r=%b want 1 0", o_wr_v, i_req_r); end
    @(negedge clk); #1;
    checks++; if ({i_req_r, m_req_tag} !== {1'b1, wi_m}) begin errors++;
      $display("FAIL full_release: got r=%b tag=%0d want 1 %0d", i_req_r, m_req_tag, wi_m); end
    @(posedge clk); wi_m++;
    @(negedge clk);
    i_req_v = 1'b0;
    pend = 32; got = 0; stalls = 0;
    for (int c = 0; c < 100 && (pend > 0 || got < 32); c++) begin
      m_rsp_v = (pend > 0); m_rsp_tag = ri_m; m_rsp_data = {32{32'(c)}};
      #1;
      if (o_wr_v) got++;
      if (m_rsp_v && !m_rsp_r) stalls++;
      fire = m_rsp_v && m_rsp_r;
      @(posedge clk);
      if (fire) begin ri_m++; pend--; end
      @(negedge clk);
    end
    m_rsp_v = 1'b0;
    checks++; if (got !== 32) begin errors++; $display("FAIL full_drain_count: got %0d want 32", got); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL full_throughput: got %0d stalls want 0", stalls); end
  endtask

  task automatic test_stall();
    logic [1023:0] d0, d1;
    int bad;
    d0 = {32{32'h1111_0000}}; d1 = {32{32'h2222_0001}};
    @(negedge clk);
    i_req_v = 1'b1; i_req_sid = 6'd9;
    @(posedge clk); wi_m++;
    @(posedge clk); wi_m++;
    @(negedge clk);
    i_req_v = 1'b0; o_wr_r = 1'b0;
    m_rsp_v = 1'b1; m_rsp_tag = ri_m; m_rsp_data = d0;
    #1;
    checks++; if (m_rsp_r !== 1'b1) begin errors++; $display("FAIL stall_first_rsp_r: got %b want 1", m_rsp_r); end
    @(posedge clk); ri_m++;
    @(negedge clk);
    m_rsp_tag = ri_m; m_rsp_data = d1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (!(m_rsp_r === 1'b0 && o_wr_v === 1'b1 && o_wr_ptr === 8'd0 && o_wr_data === d0)) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    o_wr_r = 1'b1;
    #1;
    checks++; if (m_rsp_r !== 1'b1) begin errors++; $display("FAIL stall_release_rsp_r: got %b want 1", m_rsp_r); end
    @(posedge clk); ri_m++;
    @(negedge clk);
    m_rsp_v = 1'b0; o_rsp_r = 1'b0;
    #1;
    checks++; if ({o_wr_ptr, o_wr_sid, o_wr_data == d1} !== {8'd1, 6'd9, 1'b1}) begin errors++;
      $display("FAIL stall_second: got ptr=%0d sid=%0d want 1 9", o_wr_ptr, o_wr_sid); end
    checks++; if ({o_rsp_v, o_rsp_sid, o_wr_v} !== {1'b1, 6'd9, 1'b0}) begin errors++;
      $display("FAIL stall_r_block: got rsp_v=%b sid=%0d wr_v=%b want 1 9 0", o_rsp_v, o_rsp_sid, o_wr_v); end
    o_rsp_r = 1'b1;
    #1;
    checks++; if (o_wr_v !== 1'b1) begin errors++; $display("FAIL stall_r_pass: got wr_v=%b want 1", o_wr_v); end
    @(negedge clk); #1;
    checks++; if ({o_wr_v, o_rsp_v} !== 2'b01) begin errors++; $display("FAIL stall_tail: got wr_v=%b rsp_v=%b want 0 1", o_wr_v, o_rsp_v); end
    @(negedge clk);
  endtask

  task automatic test_clear();
    logic [4:0] tag;
    logic [7:0] ptr;
    logic ok;
    for (int i = 0; i < 9; i++) line(6'd7, '0, 32'(1000 + i), tag, ptr, ok);
    checks++; if ({ok, ptr} !== {1'b1, 8'd8}) begin errors++; $display("FAIL clear_setup: got ok=%b ptr=%0d want 1 8", ok, ptr); end
    line(6'd7, 64'd1 << 7, 32'd2000, tag, ptr, ok);
    checks++; if ({ok, ptr} !== {1'b1, 8'd0}) begin errors++; $display("FAIL clear_collide: got ok=%b ptr=%0d want 1 0", ok, ptr); end
    line(6'd7, '0, 32'd2001, tag, ptr, ok);
    checks++; if ({ok, ptr} !== {1'b1, 8'd1}) begin errors++; $display("FAIL clear_next: got ok=%b ptr=%0d want 1 1", ok, ptr); end
    @(negedge clk);
    i_clr_v = 64'd1 << 3;
    @(negedge clk);
    i_clr_v = '0;
    line(6'd3, '0, 32'd2002, tag, ptr, ok);
    checks++; if ({ok, ptr} !== {1'b1, 8'd0}) begin errors++; $display("FAIL clear_alone: got ok=%b ptr=%0d want 1 0", ok, ptr); end
  endtask

  task automatic test_async_reset();
    logic [4:0] tag;
    logic [7:0] ptr;
    logic ok;
    @(negedge clk);
    o_rsp_r = 1'b0;
    i_req_v = 1'b1; i_req_sid = 6'd4;
    repeat (4) begin @(posedge clk); wi_m++; end
    @(negedge clk);
    i_req_v = 1'b0;
    m_rsp_v = 1'b1; m_rsp_tag = ri_m; m_rsp_data = {32{32'hAAAA_0000}};
    @(posedge clk); ri_m++;
    @(negedge clk);
    m_rsp_tag = ri_m; m_rsp_data = {32{32'hBBBB_0001}};
    @(posedge clk); ri_m++;
    @(negedge clk);
    m_rsp_v = 1'b0;
    #1;
    checks++; if ({o_rsp_v, o_wr_v, m_rsp_r} !== 3'b100) begin errors++;
      $display("FAIL areset_pre: got rsp_v=%b wr_v=%b rsp_r=%b want 1 0 0", o_rsp_v, o_wr_v, m_rsp_r); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({o_rsp_v, o_wr_v, m_rsp_r} !== 3'b001) begin errors++;
      $display("FAIL areset_now: got rsp_v=%b wr_v=%b rsp_r=%b want 0 0 1", o_rsp_v, o_wr_v, m_rsp_r); end
    @(negedge clk);
    reset = 1'b0; o_rsp_r = 1'b1;
    wi_m = '0; ri_m = '0;
    line(6'd4, '0, 32'd3000, tag, ptr, ok);
    checks++; if ({ok, tag, ptr} !== {1'b1, 5'd0, 8'd0}) begin errors++;
      $display("FAIL areset_after: got ok=%b tag=%0d ptr=%0d want 1 0 0", ok, tag, ptr); end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_ptr_wrap();
    test_full();
    test_stall();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
